// File: rtl/masked_random_source_pkg.sv
// Shared types, constants and lane arithmetic for the masked random source.
package masked_random_source_pkg;

  // Seed substituted for an all-zero word; xorshift32 never leaves zero.
  localparam logic [31:0] XORSHIFT_ZERO_SUBST = 32'h9E3779B9;

  typedef logic [31:0] rand_lane_t;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_SEEDING  = 2'd1,
    ST_RUNNING  = 2'd2
  } rng_state_e;

  // One xorshift32 step (13/17/5 triple).
  function automatic rand_lane_t xorshift32_next(input rand_lane_t x);
    rand_lane_t t;
    t = x ^ (x << 5'd13);
    t = t ^ (t >> 5'd17);
    t = t ^ (t << 5'd5);
    return t;
  endfunction

  // Replace a zero seed with a non-zero constant so the lane cannot lock up.
  function automatic rand_lane_t seed_guard(input rand_lane_t s);
    return (s == 32'h0000_0000) ? XORSHIFT_ZERO_SUBST : s;
  endfunction

endpackage

// File: rtl/masked_random_source_xorshift32_lane.sv
// One 32-bit xorshift32 generator lane with a guarded seed-load path.
module masked_random_source_xorshift32_lane
  import masked_random_source_pkg::*;
(
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_load,
  input  logic [31:0] in_seed,
  input  logic        in_step,
  output logic [31:0] out_state
);

  rand_lane_t state_q;
  rand_lane_t state_d;

  // Load takes priority over stepping; otherwise hold the current state.
  always_comb begin
    state_d = state_q;
    if (in_load) begin
      state_d = seed_guard(in_seed);
    end else if (in_step) begin
      state_d = xorshift32_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // Lane state register, cleared asynchronously.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_state = state_q;

endmodule

// File: rtl/masked_random_source.sv
// Random-bit producer for masked gadgets: serially seeded xorshift32 lanes,
// valid/ready delivery and a draw budget that raises a reseed request.
module masked_random_source
  import masked_random_source_pkg::*;
#(
  parameter int RAND_WIDTH = 16,
  parameter int MAX_DRAWS  = 1024
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic [31:0]           in_seed,
  input  logic                  in_seed_valid,
  output logic                  out_seed_ready,
  output logic [RAND_WIDTH-1:0] out_random,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic                  out_reseed_req
);

  localparam int NUM_LANES = (RAND_WIDTH + 31) / 32;
  localparam int LANE_BITS = NUM_LANES * 32;
  localparam int LCNT_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int DRAW_W    = $clog2(MAX_DRAWS + 1);

  localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(NUM_LANES - 1);
  localparam logic [DRAW_W-1:0] DRAW_MAX  = DRAW_W'(MAX_DRAWS);

  rng_state_e          state_q, state_d;
  logic [LCNT_W-1:0]   lane_cnt_q, lane_cnt_d;
  logic [DRAW_W-1:0]   draw_q, draw_d;

  logic                handshake_s;
  logic                load_word_s;
  logic                seed_done_s;
  logic [LANE_BITS-1:0] lanes_flat_s;

  assign handshake_s = (state_q == ST_RUNNING) && in_ready;
  assign load_word_s = (state_q == ST_SEEDING) && in_seed_valid;
  assign seed_done_s = load_word_s && (lane_cnt_q == LAST_LANE);

  // FSM state register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_UNSEEDED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; the cycle that requests seeding never consumes a word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNSEEDED: state_d = in_seed_valid ? ST_SEEDING : ST_UNSEEDED;
      ST_SEEDING:  state_d = seed_done_s ? ST_RUNNING : ST_SEEDING;
      ST_RUNNING:  state_d = in_seed_valid ? ST_SEEDING : ST_RUNNING;
      default:     state_d = ST_UNSEEDED;
    endcase
  end

  // FSM outputs: seed port open only while seeding, bits valid only while running.
  always_comb begin
    out_seed_ready = 1'b0;
    out_valid      = 1'b0;
    case (state_q)
      ST_SEEDING: out_seed_ready = 1'b1;
      ST_RUNNING: out_valid      = 1'b1;
      default: begin
        out_seed_ready = 1'b0;
        out_valid      = 1'b0;
      end
    endcase
  end

  // Lane pointer and saturating draw counter next-state.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    draw_d     = draw_q;
    if (seed_done_s) begin
      lane_cnt_d = '0;
      draw_d     = '0;
    end else if (load_word_s) begin
      lane_cnt_d = lane_cnt_q + LCNT_W'(1);
    end else if (handshake_s && (draw_q != DRAW_MAX)) begin
      draw_d = draw_q + DRAW_W'(1);
    end else begin
      lane_cnt_d = lane_cnt_q;
      draw_d     = draw_q;
    end
  end

  // Counter registers.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      lane_cnt_q <= '0;
      draw_q     <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      draw_q     <= draw_d;
    end
  end

  assign out_reseed_req = (draw_q == DRAW_MAX);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic load_s;
    assign load_s = load_word_s && (lane_cnt_q == LCNT_W'(gi));
    masked_random_source_xorshift32_lane u_lane (
      .in_clock  (in_clock),
      .in_reset  (in_reset),
      .in_load   (load_s),
      .in_seed   (in_seed),
      .in_step   (handshake_s),
      .out_state (lanes_flat_s[gi*32 +: 32])
    );
  end

  // Bits of the last lane above RAND_WIDTH keep advancing but are not exposed.
  if (LANE_BITS > RAND_WIDTH) begin : g_trunc
    logic unused_top_s;
    assign unused_top_s = ^lanes_flat_s[LANE_BITS-1:RAND_WIDTH];
  end

  assign out_random = lanes_flat_s[RAND_WIDTH-1:0];

endmodule
